// File: rtl/instr_queue.sv
// Instruction queue between the icache and decode: sequential fetch with a single
// outstanding request, circular buffer of returned words, one issue per cycle.
module instr_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PTR_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        is_exception_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        is_ready_in,
  output logic        fetch_req_out,
  output logic [31:0] fetch_pc_out,
  input  logic        fetch_valid_in,
  input  logic [31:0] fetch_instr_in,
  output logic        issue_valid_out,
  output logic [31:0] issue_instr_out,
  output logic [31:0] issue_pc_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             req_q, req_d;
  logic             issue_valid_q, issue_valid_d;
  logic [31:0]      issue_instr_q, issue_instr_d;
  logic [31:0]      issue_pc_q, issue_pc_d;
  logic             has_space_s;
  logic             enq_s;
  logic             deq_s;

  assign has_space_s = (count_q < FULL_CNT);
  assign enq_s       = (state_q == S_WAIT) && fetch_valid_in && !is_exception_in;
  assign deq_s       = (count_q != '0) && is_ready_in && !is_exception_in;

  // Fetch FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Fetch FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!is_exception_in && has_space_s) state_d = S_WAIT;
        else                                 state_d = S_IDLE;
      end
      S_WAIT: begin
        if (fetch_valid_in)       state_d = S_IDLE;
        else if (is_exception_in) state_d = S_DISCARD;
        else                      state_d = S_WAIT;
      end
      S_DISCARD: begin
        // The stale response retires the outstanding request even under a new exception.
        if (fetch_valid_in) state_d = S_IDLE;
        else                state_d = S_DISCARD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch FSM output logic: request pulse leaving IDLE
  always_comb begin
    req_d = 1'b0;
    if ((state_q == S_IDLE) && has_space_s && !is_exception_in) req_d = 1'b1;
    else                                                        req_d = 1'b0;
  end

  // Queue pointers, occupancy, fetch PC and issue stage next state
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;
    issue_valid_d = 1'b0;
    issue_instr_d = issue_instr_q;
    issue_pc_d    = issue_pc_q;
    if (is_exception_in) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc_in;
    end else begin
      if (enq_s) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        tail_d     = tail_q;
      end
      if (deq_s) begin
        issue_valid_d = 1'b1;
        issue_instr_d = instr_q[head_q];
        issue_pc_d    = pc_q[head_q];
        head_d        = head_q + PTR_W'(1);
      end else begin
        head_d        = head_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      req_q         <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= 32'h0;
      issue_pc_q    <= 32'h0;
    end else if (rdy) begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      req_q         <= req_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      issue_pc_q    <= issue_pc_d;
    end
  end

  // Entry storage; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (!rst && rdy && enq_s) begin
      instr_q[tail_q] <= fetch_instr_in;
      pc_q[tail_q]    <= fetch_pc_q;
    end
  end

  // A held request stays invisible to the icache while rdy is low.
  assign fetch_req_out   = req_q & rdy;
  assign fetch_pc_out    = fetch_pc_q;
  assign issue_valid_out = issue_valid_q;
  assign issue_instr_out = issue_instr_q;
  assign issue_pc_out    = issue_pc_q;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: 1-cycle icache model plus an issue scoreboard.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, is_exception_in, is_ready_in, fetch_valid_in;
  logic [31:0] redirect_pc_in, fetch_instr_in;
  logic        fetch_req_out, issue_valid_out;
  logic [31:0] fetch_pc_out, issue_instr_out, issue_pc_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      exp_q[$];
  bit          pend;
  logic [31:0] pend_pc;
  int          pend_epoch;
  int          epoch;
  logic [31:0] next_req_pc;
  int          issue_cnt = 0;
  logic [31:0] last_issue_pc = 32'h0;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(16), .PTR_W(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .is_exception_in(is_exception_in),
    .redirect_pc_in (redirect_pc_in),
    .is_ready_in    (is_ready_in),
    .fetch_req_out  (fetch_req_out),
    .fetch_pc_out   (fetch_pc_out),
    .fetch_valid_in (fetch_valid_in),
    .fetch_instr_in (fetch_instr_in),
    .issue_valid_out(issue_valid_out),
    .issue_instr_out(issue_instr_out),
    .issue_pc_out   (issue_pc_out)
  );

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // icache model: answers each request one cycle later and pushes live words to the scoreboard
  initial begin : icache_model
    logic re, exc_e, rst_e;
    logic [31:0] red_e;
    pend = 1'b0; epoch = 0; pend_epoch = 0; next_req_pc = 32'h0; pend_pc = 32'h0;
    fetch_valid_in = 1'b0; fetch_instr_in = 32'h0;
    forever begin
      @(posedge clk);
      re = rdy; exc_e = is_exception_in && rdy; rst_e = rst; red_e = redirect_pc_in;
      #2;
      if (rst_e) begin
        pend = 1'b0; exp_q.delete(); epoch++; next_req_pc = 32'h0;
      end else begin
        if (exc_e) begin
          epoch++; exp_q.delete(); next_req_pc = red_e;
        end
        if (fetch_valid_in && re) begin
          pend = 1'b0;
          if (pend_epoch == epoch) begin
            exp_q.push_back({pend_pc, word_of(pend_pc)});
            next_req_pc = next_req_pc + 32'd4;
          end
        end
      end
      fetch_valid_in = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend && rdy) begin
          fetch_valid_in = 1'b1;
          fetch_instr_in = word_of(pend_pc);
        end
        if (fetch_req_out) begin
          checks++;
          if (pend) begin
            errors++; $display("FAIL req_outstanding: got request at pc %h, required none while one is pending", fetch_pc_out);
          end
          checks++;
          if (fetch_pc_out !== next_req_pc) begin
            errors++; $display("FAIL req_pc: got %h, required %h", fetch_pc_out, next_req_pc);
          end
          pend = 1'b1; pend_pc = fetch_pc_out; pend_epoch = epoch;
        end
      end
    end
  end

  // Issue monitor: pops the scoreboard for every issue registered on an enabled edge
  initial begin : issue_monitor
    logic ok_e;
    entry_t e;
    forever begin
      @(posedge clk);
      ok_e = rdy && !rst;
      @(negedge clk);
      if (ok_e && issue_valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL issue_unexpected: got pc %h, required no issue", issue_pc_out);
        end else begin
          e = exp_q.pop_front();
          if (issue_pc_out !== e.pc || issue_instr_out !== e.instr) begin
            errors++; $display("FAIL issue_order: got pc %h instr %h, required pc %h instr %h",
                               issue_pc_out, issue_instr_out, e.pc, e.instr);
          end
        end
        issue_cnt++;
        last_issue_pc = issue_pc_out;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; is_exception_in = 1'b0; is_ready_in = 1'b0; redirect_pc_in = 32'h0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step(1);
      if (fetch_req_out) ok = 1'b1;
    end
  endtask

  task automatic wait_issue(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step(1);
      if (issue_valid_out) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; is_exception_in = 1'b0; is_ready_in = 1'b0; redirect_pc_in = 32'h0;
    step(3);
    checks++; if (fetch_req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", fetch_req_out); end
    checks++; if (fetch_pc_out !== 32'h0) begin errors++; $display("FAIL reset_fetch_pc: got %h, required 0", fetch_pc_out); end
    checks++; if (issue_valid_out !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b, required 0", issue_valid_out); end
    checks++; if (issue_instr_out !== 32'h0) begin errors++; $display("FAIL reset_issue_instr: got %h, required 0", issue_instr_out); end
    checks++; if (issue_pc_out !== 32'h0) begin errors++; $display("FAIL reset_issue_pc: got %h, required 0", issue_pc_out); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    bit ok;
    int start;
    is_ready_in = 1'b1;
    wait_req(10, ok);
    checks++; if (!ok || fetch_pc_out !== 32'h0) begin errors++; $display("FAIL stream_first_req: got ok=%0d pc %h, required pc 0", ok, fetch_pc_out); end
    start = issue_cnt;
    for (int i = 0; i < 200 && issue_cnt < start + 8; i++) step(1);
    checks++; if (issue_cnt < start + 8 || last_issue_pc !== 32'h1C) begin
      errors++; $display("FAIL stream_8th_issue: got %0d issues last pc %h, required 8 issues last pc 1c", issue_cnt - start, last_issue_pc);
    end
  endtask

  task automatic test_full();
    bit seen;
    logic [31:0] first_pc;
    do_reset();
    step(70);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (fetch_req_out !== 1'b0 || fetch_pc_out !== 32'h40) begin
        errors++; $display("FAIL full_stall: got req %b pc %h, required req 0 pc 40", fetch_req_out, fetch_pc_out);
      end
    end
    step(1);
    is_ready_in = 1'b1;
    seen = 1'b0; first_pc = 32'h0;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++; if (issue_valid_out !== 1'b1 || issue_pc_out !== 32'(i * 4)) begin
        errors++; $display("FAIL full_drain_%0d: got valid %b pc %h, required valid 1 pc %h", i, issue_valid_out, issue_pc_out, 32'(i * 4));
      end
      if (fetch_req_out && !seen) begin seen = 1'b1; first_pc = fetch_pc_out; end
    end
    checks++; if (!seen || first_pc !== 32'h40) begin
      errors++; $display("FAIL full_resume: got seen=%0d pc %h, required pc 40", seen, first_pc);
    end
  endtask

  task automatic test_exc_wait();
    bit ok, hit, stray;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #3;
      if (exp_q.size() >= 5 && fetch_req_out) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL exc_wait_setup: got no request with 5 queued, required one"); end
    is_exception_in = 1'b1; redirect_pc_in = 32'h1000; is_ready_in = 1'b1;
    step(1);
    is_exception_in = 1'b0;
    checks++; if (issue_valid_out !== 1'b0) begin errors++; $display("FAIL exc_wait_no_issue: got %b, required 0", issue_valid_out); end
    stray = 1'b0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1);
      if (issue_valid_out) stray = 1'b1;
      if (fetch_req_out) ok = 1'b1;
    end
    checks++; if (!ok || fetch_pc_out !== 32'h1000 || stray) begin
      errors++; $display("FAIL exc_wait_redirect: got ok=%0d pc %h stray=%0d, required pc 1000 no stray", ok, fetch_pc_out, stray);
    end
    wait_issue(20, ok);
    checks++; if (!ok || issue_pc_out !== 32'h1000 || issue_instr_out !== word_of(32'h1000)) begin
      errors++; $display("FAIL exc_wait_first_issue: got pc %h instr %h, required pc 1000 instr %h", issue_pc_out, issue_instr_out, word_of(32'h1000));
    end
  endtask

  task automatic test_exc_valid();
    bit ok, hit;
    do_reset();
    is_ready_in = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk); #3;
      if (fetch_valid_in) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL exc_valid_setup: got no response, required one"); end
    is_exception_in = 1'b1; redirect_pc_in = 32'h2000;
    step(1);
    is_exception_in = 1'b0;
    wait_req(20, ok);
    checks++; if (!ok || fetch_pc_out !== 32'h2000) begin errors++; $display("FAIL exc_valid_redirect: got ok=%0d pc %h, required pc 2000", ok, fetch_pc_out); end
    wait_issue(20, ok);
    checks++; if (!ok || issue_pc_out !== 32'h2000) begin errors++; $display("FAIL exc_valid_first_issue: got pc %h, required 2000", issue_pc_out); end
  endtask

  task automatic test_rdy_hold();
    bit hit;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step(1);
      if (exp_q.size() >= 4) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rdy_setup: got %0d queued, required 4", exp_q.size()); end
    is_ready_in = 1'b1;
    step(1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (issue_valid_out !== 1'b1 || issue_pc_out !== 32'h0 || issue_instr_out !== word_of(32'h0) || fetch_req_out !== 1'b0) begin
        errors++; $display("FAIL rdy_hold_%0d: got valid %b pc %h req %b, required valid 1 pc 0 req 0", i, issue_valid_out, issue_pc_out, fetch_req_out);
      end
      step(1);
    end
    rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (issue_valid_out !== 1'b1 || issue_pc_out !== 32'h4) begin
      errors++; $display("FAIL rdy_resume: got valid %b pc %h, required valid 1 pc 4", issue_valid_out, issue_pc_out);
    end
  endtask

  task automatic test_wrap();
    int start;
    logic [31:0] pc_at_50;
    do_reset();
    start = issue_cnt;
    pc_at_50 = 32'hFFFF_FFFF;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #2;
      if (issue_cnt - start >= 50) begin pc_at_50 = last_issue_pc; break; end
      @(posedge clk); #1;
      is_ready_in = ($urandom_range(4, 0) == 0);
    end
    checks++; if (issue_cnt - start < 50 || pc_at_50 !== 32'hC4) begin
      errors++; $display("FAIL wrap_50: got %0d issues last pc %h, required 50 issues last pc c4", issue_cnt - start, pc_at_50);
    end
    is_ready_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; is_exception_in = 1'b0; is_ready_in = 1'b0; redirect_pc_in = 32'h0;
    test_reset();
    test_stream();
    test_full();
    test_exc_wait();
    test_exc_valid();
    test_rdy_hold();
    test_wrap();
    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
